pipe_stall_ctrl: RTL and testbench

- Central stall/flush scheduler for the five-stage MiniMIPS32 pipeline.
- Generates per-stage hold and bubble controls for the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.
- Sequences the fixed-latency iterative divider in EXE: issues the start pulse, counts its latency and steers EXE result selection.
- Arbitrates three requests, highest priority first: exception flush, divider, load-use hazard from ID.

---
 rtl/pipe_stall_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler for the five-stage MiniMIPS32 pipeline: per-stage hold and
// bubble controls plus divider sequencing. Define STALL_PERF_CNT_EN to add stall-cycle counters.
module pipe_stall_ctrl #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        id_stallreq,
  input  logic        exe_div_req,
  input  logic        flush_req,
  output logic [4:0]  stall,
  output logic        idexe_bubble,
  output logic        exemem_bubble,
  output logic        flush,
  output logic        div_start,
  output logic        div_abort,
  output logic        div_result_sel,
  output logic [31:0] perf_div_cyc,
  output logic [31:0] perf_lu_cyc,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Priority: flush, then divider, then load-use. Outputs are forced low while reset is held.
  always_comb begin
    stall          = 5'b00000;
    idexe_bubble   = 1'b0;
    exemem_bubble  = 1'b0;
    flush          = 1'b0;
    div_start      = 1'b0;
    div_abort      = 1'b0;
    div_result_sel = 1'b0;
    state_next     = state;
    cnt_next       = cnt;
    if (cpu_rst) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (flush_req) begin
      flush      = 1'b1;
      div_abort  = (state == BUSY);
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (exe_div_req) begin
            div_start     = 1'b1;
            stall         = 5'b00111;
            exemem_bubble = 1'b1;
            cnt_next      = CNT_LOAD;
            state_next    = BUSY;
          end else if (id_stallreq) begin
            stall        = 5'b00011;
            idexe_bubble = 1'b1;
          end
        end
        BUSY: begin
          stall         = 5'b00111;
          exemem_bubble = 1'b1;
          cnt_next      = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_next = DONE;
        end
        DONE: begin
          // exe_div_req is still high here for the finishing DIV; it must not reissue.
          div_result_sel = 1'b1;
          state_next     = IDLE;
          cnt_next       = '0;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign dbg_state = state;

`ifdef STALL_PERF_CNT_EN
  logic div_cyc_en;
  assign div_cyc_en = div_start | ((state == BUSY) & ~flush_req);

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      perf_div_cyc <= '0;
      perf_lu_cyc  <= '0;
    end else begin
      if (div_cyc_en && (perf_div_cyc != 32'hFFFF_FFFF)) perf_div_cyc <= perf_div_cyc + 32'd1;
      if (idexe_bubble && (perf_lu_cyc != 32'hFFFF_FFFF)) perf_lu_cyc <= perf_lu_cyc + 32'd1;
    end
  end
`else
  assign perf_div_cyc = 32'h0;
  assign perf_lu_cyc  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with DIV_CYCLES=4; inputs change on the falling
// edge and combinational outputs are sampled 1ns later, well before the rising edge.
module tb_pipe_stall_ctrl;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst     = 1'b1;
  logic        id_stallreq = 1'b0;
  logic        exe_div_req = 1'b0;
  logic        flush_req   = 1'b0;
  logic [4:0]  stall;
  logic        idexe_bubble, exemem_bubble, flush, div_start, div_abort, div_result_sel;
  logic [31:0] perf_div_cyc, perf_lu_cyc;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // {stall[4:0], idexe_bubble, exemem_bubble, flush, div_start, div_abort, div_result_sel}
  logic [10:0] outs;
  assign outs = {stall, idexe_bubble, exemem_bubble, flush, div_start, div_abort, div_result_sel};

  localparam logic [10:0] O_ZERO  = 11'b00000_000000;
  localparam logic [10:0] O_ISSUE = 11'b00111_010100;
  localparam logic [10:0] O_BUSY  = 11'b00111_010000;
  localparam logic [10:0] O_DONE  = 11'b00000_000001;
  localparam logic [10:0] O_LU    = 11'b00011_100000;
  localparam logic [10:0] O_FL    = 11'b00000_001000;
  localparam logic [10:0] O_FLAB  = 11'b00000_001010;

`ifdef STALL_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  pipe_stall_ctrl #(.DIV_CYCLES(4), .CNT_W(8)) dut (
    .cpu_clk_50M   (cpu_clk_50M),
    .cpu_rst       (cpu_rst),
    .id_stallreq   (id_stallreq),
    .exe_div_req   (exe_div_req),
    .flush_req     (flush_req),
    .stall         (stall),
    .idexe_bubble  (idexe_bubble),
    .exemem_bubble (exemem_bubble),
    .flush         (flush),
    .div_start     (div_start),
    .div_abort     (div_abort),
    .div_result_sel(div_result_sel),
    .perf_div_cyc  (perf_div_cyc),
    .perf_lu_cyc   (perf_lu_cyc),
    .dbg_state     (dbg_state)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  task automatic do_reset();
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b1; id_stallreq = 1'b0; exe_div_req = 1'b0; flush_req = 1'b0;
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b0;
  endtask

  task automatic test_reset();
    // requests present during reset must not leak to the outputs
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b1; exe_div_req = 1'b1; id_stallreq = 1'b1;
    #1;
    checks++;
    if (outs !== O_ZERO) begin errors++; $display("FAIL reset_hold outs=%b exp=%b", outs, O_ZERO); end
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b0; id_stallreq = 1'b0;
    #1;
    checks++;
    if (outs !== O_ISSUE) begin errors++; $display("FAIL reset_issue outs=%b exp=%b", outs, O_ISSUE); end
    @(negedge cpu_clk_50M);
    #1;
    checks++;
    if (outs !== O_BUSY || dbg_state !== 2'd1) begin
      errors++; $display("FAIL reset_busy outs=%b st=%0d exp=%b st=1", outs, dbg_state, O_BUSY);
    end
    #2 cpu_rst = 1'b1;
    #1;
    checks++;
    if (outs !== O_ZERO || dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_midbusy outs=%b st=%0d exp=%b st=0", outs, dbg_state, O_ZERO);
    end
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b0; exe_div_req = 1'b0;
    #1;
    checks++;
    if (outs !== O_ZERO || dbg_state !== 2'd0 || perf_div_cyc !== 32'd0 || perf_lu_cyc !== 32'd0) begin
      errors++;
      $display("FAIL reset_release outs=%b st=%0d pd=%0d pl=%0d exp all 0", outs, dbg_state, perf_div_cyc, perf_lu_cyc);
    end
  endtask

  task automatic test_div();
    logic [10:0] exp_v [5] = '{O_ISSUE, O_BUSY, O_BUSY, O_BUSY, O_DONE};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge cpu_clk_50M);
      exe_div_req = 1'b1;
      #1;
      checks++;
      if (outs !== exp_v[i]) begin errors++; $display("FAIL div_c%0d outs=%b exp=%b", i, outs, exp_v[i]); end
    end
    @(negedge cpu_clk_50M);
    exe_div_req = 1'b0;
    #1;
    checks++;
    if (outs !== O_ZERO || perf_div_cyc !== (PERF_ON ? 32'd4 : 32'd0)) begin
      errors++; $display("FAIL div_after outs=%b pd=%0d exp=%b pd=%0d", outs, perf_div_cyc, O_ZERO, PERF_ON ? 4 : 0);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge cpu_clk_50M);
      id_stallreq = 1'b1;
      #1;
      checks++;
      if (outs !== O_LU) begin errors++; $display("FAIL lu_c%0d outs=%b exp=%b", i, outs, O_LU); end
    end
    @(negedge cpu_clk_50M);
    id_stallreq = 1'b0;
    #1;
    checks++;
    if (outs !== O_ZERO || perf_lu_cyc !== (PERF_ON ? 32'd2 : 32'd0) || perf_div_cyc !== 32'd0) begin
      errors++; $display("FAIL lu_after outs=%b pl=%0d pd=%0d exp=%b pl=%0d pd=0", outs, perf_lu_cyc, perf_div_cyc, O_ZERO, PERF_ON ? 2 : 0);
    end
  endtask

  task automatic test_flush_mid_div();
    logic [10:0] exp_v [3] = '{O_ISSUE, O_BUSY, O_FLAB};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk_50M);
      exe_div_req = (i < 2);
      flush_req   = (i == 2);
      #1;
      checks++;
      if (outs !== exp_v[i]) begin errors++; $display("FAIL flush_c%0d outs=%b exp=%b", i, outs, exp_v[i]); end
    end
    @(negedge cpu_clk_50M);
    flush_req = 1'b0;
    #1;
    checks++;
    if (outs !== O_ZERO || dbg_state !== 2'd0 || perf_div_cyc !== (PERF_ON ? 32'd2 : 32'd0)) begin
      errors++; $display("FAIL flush_after outs=%b st=%0d pd=%0d exp=%b st=0 pd=%0d", outs, dbg_state, perf_div_cyc, O_ZERO, PERF_ON ? 2 : 0);
    end
  endtask

  task automatic test_priority();
    logic [10:0] exp_v [6] = '{O_FL, O_ISSUE, O_BUSY, O_BUSY, O_BUSY, O_DONE};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge cpu_clk_50M);
      exe_div_req = 1'b1; id_stallreq = 1'b1; flush_req = (i == 0);
      #1;
      checks++;
      if (outs !== exp_v[i]) begin errors++; $display("FAIL prio_c%0d outs=%b exp=%b", i, outs, exp_v[i]); end
    end
    @(negedge cpu_clk_50M);
    exe_div_req = 1'b0; id_stallreq = 1'b0;
    #1;
    checks++;
    if (outs !== O_ZERO || perf_lu_cyc !== 32'd0 || perf_div_cyc !== (PERF_ON ? 32'd4 : 32'd0)) begin
      errors++; $display("FAIL prio_after outs=%b pl=%0d pd=%0d exp=%b pl=0 pd=%0d", outs, perf_lu_cyc, perf_div_cyc, O_ZERO, PERF_ON ? 4 : 0);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_v [10] = '{O_ISSUE, O_BUSY, O_BUSY, O_BUSY, O_DONE,
                                O_ISSUE, O_BUSY, O_BUSY, O_BUSY, O_DONE};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge cpu_clk_50M);
      exe_div_req = 1'b1;
      #1;
      checks++;
      if (outs !== exp_v[i]) begin errors++; $display("FAIL b2b_c%0d outs=%b exp=%b", i, outs, exp_v[i]); end
    end
    @(negedge cpu_clk_50M);
    exe_div_req = 1'b0;
    #1;
    checks++;
    if (outs !== O_ZERO || perf_div_cyc !== (PERF_ON ? 32'd8 : 32'd0)) begin
      errors++; $display("FAIL b2b_after outs=%b pd=%0d exp=%b pd=%0d", outs, perf_div_cyc, O_ZERO, PERF_ON ? 8 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_div();
    test_load_use();
    test_flush_mid_div();
    test_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
